sd_adc: RTL
===========

// Module: sd_adc
//
// PURPOSE
// First-order delta-sigma ADC front end; the receive-side counterpart of the 1-bit delta-sigma DAC.
// An external comparator (LVDS pair or FPGA input) compares the analog input against fb integrated
// by an external RC (3k3 / 4n7). This block samples the comparator, drives fb, counts ones over a
// fixed window and emits an N-bit sample per window in excess-2**MSBO format (DAC input format).
//
// PARAMETERS
// MSBO         7   MSB of output sample q; window length W = 2**(MSBO+1) ce ticks
// SYNC_STAGES  2   synchronizer flops on cmp_in; legal range 2..4
//
// PORTS
// clock    in   1         system clock; all logic on rising edge
// reset    in   1         synchronous, active-low
// ce       in   1         oversampling tick; logic advances only when 1
// cmp_in   in   1         asynchronous comparator output (1 = analog input above integrated fb)
// fb       out  1         feedback bit to external RC; registered, IOB flop
// q        out  MSBO+1    last completed sample, excess 2**MSBO (mid-scale = 2**MSBO)
// valid    out  1         one-clock strobe: q updated this clock
//
// BEHAVIOUR
// - Clock is clock; reset is reset, synchronous, active-low; no asynchronous logic beyond synchronizer.
// - Reset values: sync chain all 0, fb=0, ones count=0, tick count=0, q=2**MSBO, valid=0.
// - Synchronizer: cmp_in shifts through SYNC_STAGES flops every clock, independent of ce; s = last stage.
// - On clock with ce=1: fb <= s; ones <= ones + s; tick <= tick + 1 (wraps at W).
// - Window end = ce=1 clock with tick == W-1: q <= min(ones + s, 2**(MSBO+1)-1); ones <= 0;
//   tick <= 0; valid <= 1 on that same edge, so valid and new q are visible together for exactly one clock.
// - Window of all ones (count W) saturates to 2**(MSBO+1)-1; all zeros gives 0. No other clipping.
// - ones counter width MSBO+2 bits (holds 0..W); tick counter MSBO+1 bits.
// - Latency: cmp_in to fb = SYNC_STAGES clocks + wait for next ce tick; window to q = 0 extra clocks.
// - ce=0: fb, ones, tick, q hold; valid drops to 0 after any strobe; sync chain still runs.
// - valid asserted only on a window-end tick; never two consecutive clocks high, even when ce is always 1
//   (W >= 2).
// - Reset mid-window: partial window discarded, no valid; q returns to 2**MSBO; first post-reset window
//   starts on the first ce tick after reset release and includes the zeroed sync stages.
// - reset low with ce=1: reset wins.
// - fb loop polarity: s=1 drives fb=1, charging the RC toward the input; no inversion in logic.
//
// TESTING (MSBO=7, SYNC_STAGES=2, W=256)
// 1. Release reset, ce=1, cmp_in=1 constant -> first valid 256 clocks after release with q=254,
//    then q=255 every 256 clocks.
// 2. ce=1, cmp_in=0 constant -> q=0, valid high 1 clock in every 256, fb stays 0.
// 3. ce=1, cmp_in toggles every clock -> every window from the second on gives q=128; fb toggles
//    2 clocks behind cmp_in.
// 4. ce high 1 clock in 4, cmp_in=1 -> valid period 1024 clocks; fb/tick change only on ce clocks;
//    valid never during ce=0.
// 5. Reset pulsed low 1 clock at tick 100 -> q=128 immediately; no valid until 256 ce ticks after release.
// 6. Closed loop with behavioural RC model (tau = 3k3*4n7), analog input 0.75 full scale, ce=1
//    -> after 4 windows q in 190..194.

Source files
------------

// File: rtl/sd_adc.sv
// First-order delta-sigma ADC front end: synchronizes the comparator, drives the RC feedback bit
// and emits the ones count of each W = 2**(MSBO+1) tick window as an excess-2**MSBO sample.
module sd_adc #(
  parameter int unsigned MSBO        = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          cmp_in,
  output logic          fb,
  output logic [MSBO:0] q,
  output logic          valid
);

  localparam int unsigned QW = MSBO + 1;
  localparam logic [MSBO:0] Q_MID = QW'(1) << MSBO;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   fb_q, fb_d;
  logic [QW:0]            ones_q, ones_d;
  logic [MSBO:0]          tick_q, tick_d;
  logic [MSBO:0]          q_q, q_d;
  logic                   valid_q, valid_d;

  logic        s;
  logic [QW:0] ones_sum;
  logic        win_end;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], cmp_in};
    s        = sync_q[SYNC_STAGES-1];
    ones_sum = ones_q + {{QW{1'b0}}, s};
    win_end  = ce && (tick_q == '1);

    fb_d    = fb_q;
    ones_d  = ones_q;
    tick_d  = tick_q;
    q_d     = q_q;
    valid_d = 1'b0;

    if (ce) begin
      fb_d   = s;
      ones_d = ones_sum;
      tick_d = tick_q + 1'b1;
    end

    // The sample at the closing tick already includes this tick's bit; only a full window
    // (count == W) overflows the output range, hence the single-bit saturation test.
    if (win_end) begin
      q_d     = ones_sum[QW] ? '1 : ones_sum[MSBO:0];
      ones_d  = '0;
      tick_d  = '0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      fb_q    <= 1'b0;
      ones_q  <= '0;
      tick_q  <= '0;
      q_q     <= Q_MID;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fb_q    <= fb_d;
      ones_q  <= ones_d;
      tick_q  <= tick_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign fb    = fb_q;
  assign q     = q_q;
  assign valid = valid_q;

endmodule
